// File: rtl/hilo_mdu_pkg.sv
// Shared op codes and latched-operation control for the HI/LO multiply/divide unit.
// SIG_ALU_* codes sit beside the existing ALU_MTHI/ALU_MTLO encodings.
package hilo_mdu_pkg;

  localparam logic [4:0] ALU_MTHI      = 5'd14;
  localparam logic [4:0] ALU_MTLO      = 5'd15;
  localparam logic [4:0] SIG_ALU_MULT  = 5'd24;
  localparam logic [4:0] SIG_ALU_MULTU = 5'd25;
  localparam logic [4:0] SIG_ALU_DIV   = 5'd26;
  localparam logic [4:0] SIG_ALU_DIVU  = 5'd27;

  // Captured at start: what the FIX cycle must do to the raw magnitude result.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate quotient (div) or full product (mul)
    logic neg_r;   // negate remainder: follows dividend sign
    logic divz;    // divisor was zero
  } mdu_ctl_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == SIG_ALU_MULT) || (op == SIG_ALU_MULTU) ||
           (op == SIG_ALU_DIV)  || (op == SIG_ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == SIG_ALU_MULT) || (op == SIG_ALU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared 2W-bit shift register with one add/subtract per step: shift-add multiply or
// restoring divide on magnitudes; one step per cycle, W steps, last_o flags the final one.
module mdu_iter_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           is_div_i,
  input  logic [W-1:0]   opa_i,
  input  logic [W-1:0]   opb_i,
  output logic [2*W-1:0] acc_o,
  output logic           last_o
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           div_q;
  logic [W+1:0]   add_l, add_r, sum;

  // One adder serves both: divide subtracts the divisor from the shifted partial
  // remainder (sum MSB set means borrow), multiply adds the multiplicand when LSB is set.
  always_comb begin
    if (div_q) begin
      add_l = {1'b0, acc_q[2*W-1:W-1]};
      add_r = ~{2'b00, b_q};
    end else begin
      add_l = {2'b00, acc_q[2*W-1:W]};
      add_r = acc_q[0] ? {2'b00, b_q} : '0;
    end
    sum = add_l + add_r + {{(W+1){1'b0}}, div_q};

    if (div_q) begin
      if (sum[W+1])
        acc_d = {acc_q[2*W-2:0], 1'b0};
      else
        acc_d = {sum[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      acc_d = {sum[W:0], acc_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= {{W{1'b0}}, opa_i};
      b_q   <= opb_i;
      cnt_q <= '0;
      div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit: 34-cycle stall for mul/div (2 for mul with HILO_MDU_FAST_MULT_EN),
// MTHI/MTLO in one edge; holds the pipeline via combinational stall, ignores start while busy.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             start,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               done_q, done_d;
  mdu_ctl_t           ctl_q, ctl_d;

  logic               op_md, op_div, op_sgn;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               load, last;
  logic [2*WIDTH-1:0] acc, mul_res;
  logic [WIDTH-1:0]   quo, rem, div_lo, div_hi;

  assign op_md  = is_muldiv(op);
  assign op_div = (op == SIG_ALU_DIV) || (op == SIG_ALU_DIVU);
  assign op_sgn = is_signed_op(op);
  assign a_neg  = op_sgn & a[WIDTH-1];
  assign b_neg  = op_sgn & b[WIDTH-1];
  assign abs_a  = a_neg ? (~a + 1'b1) : a;
  assign abs_b  = b_neg ? (~b + 1'b1) : b;
  assign load   = (state_q == S_IDLE) & start & op_md & ~flush;

  mdu_iter_core #(.W(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (state_q == S_CALC),
    .is_div_i (op_div),
    .opa_i    (abs_a),
    .opb_i    (abs_b),
    .acc_o    (acc),
    .last_o   (last)
  );

`ifdef HILO_MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod_q;
  logic [2*WIDTH-1:0] ext_a, ext_b;

  // Sign-extending to 2W makes the low 2W bits of a plain multiply the signed product.
  assign ext_a = {{WIDTH{a_neg}}, a};
  assign ext_b = {{WIDTH{b_neg}}, b};

  always_ff @(posedge clk) begin
    if (rst)
      fast_prod_q <= '0;
    else if (load & ~op_div)
      fast_prod_q <= ext_a * ext_b;
  end

  assign mul_res = fast_prod_q;
`else
  assign mul_res = ctl_q.neg_q ? (~acc + 1'b1) : acc;
`endif

  assign quo    = acc[WIDTH-1:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign div_lo = ctl_q.divz ? '1     : (ctl_q.neg_q ? (~quo + 1'b1) : quo);
  assign div_hi = ctl_q.divz ? araw_q : (ctl_q.neg_r ? (~rem + 1'b1) : rem);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    araw_d  = araw_q;
    ctl_d   = ctl_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op_md) begin
              ctl_d.is_div = op_div;
              ctl_d.neg_q  = a_neg ^ b_neg;
              ctl_d.neg_r  = a_neg;
              ctl_d.divz   = (b == '0);
              araw_d       = a;
`ifdef HILO_MDU_FAST_MULT_EN
              state_d      = op_div ? S_CALC : S_FIX;
`else
              state_d      = S_CALC;
`endif
            end else if (op == ALU_MTHI) begin
              hi_d = a;
            end else if (op == ALU_MTLO) begin
              lo_d = a;
            end
          end
        end
        S_CALC: begin
          if (last)
            state_d = S_FIX;
        end
        S_FIX: begin
          if (ctl_q.is_div) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      araw_q  <= '0;
      ctl_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      araw_q  <= araw_d;
      ctl_q   <= ctl_d;
      done_q  <= done_d;
    end
  end

  assign stall = (state_q != S_IDLE) | (start & op_md & (state_q == S_IDLE));
  assign done  = done_q;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomized and directed bench for hilo_mdu against an arithmetic HI/LO reference model.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [4:0]   op;
  logic [W-1:0] a, b;
  logic         stall, done;
  logic [W-1:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .flush (flush),
    .stall (stall),
    .done  (done),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural result of a mul/div, straight from integer arithmetic.
  function automatic void ref_muldiv(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl);
    longint     ps;
    logic [63:0] pu;
    int         qs, rs;
    rh = '0;
    rl = '0;
    if (o == SIG_ALU_MULT) begin
      ps = longint'($signed(x)) * longint'($signed(y));
      pu = ps;
      rh = pu[63:32];
      rl = pu[31:0];
    end else if (o == SIG_ALU_MULTU) begin
      pu = 64'(x) * 64'(y);
      rh = pu[63:32];
      rl = pu[31:0];
    end else if (y == 32'd0) begin
      rh = x;
      rl = 32'hFFFF_FFFF;
    end else if (o == SIG_ALU_DIV) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        rh = 32'd0;
        rl = 32'h8000_0000;
      end else begin
        qs = $signed(x) / $signed(y);
        rs = $signed(x) % $signed(y);
        rh = rs;
        rl = qs;
      end
    end else begin
      rh = x % y;
      rl = x / y;
    end
  endfunction

  task automatic do_muldiv(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int st, to, exp_len;
    ref_muldiv(o, x, y, eh, el);
    exp_len = 34;
`ifdef HILO_MDU_FAST_MULT_EN
    if (o == SIG_ALU_MULT || o == SIG_ALU_MULTU) exp_len = 2;
`endif
    st = 0;
    to = 0;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    if (stall) st++;
    @(posedge clk); #1;
    start = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    while (to < 100) begin
      @(negedge clk);
      if (!stall) break;
      st++;
      to++;
    end
    chk("stall_bound", 64'(to < 100), 64'd1);
    chk("stall_len", 64'(st), 64'(exp_len));
    chk("done_rise", 64'(done), 64'd1);
    chk("hi", 64'(hi_o), 64'(eh));
    chk("lo", 64'(lo_o), 64'(el));
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  // Non-stalling ops: MTHI/MTLO and codes this unit ignores.
  task automatic do_simple(input logic [4:0] o, input logic [31:0] x);
    @(posedge clk); #1;
    op = o; a = x; b = $urandom; start = 1'b1;
    @(negedge clk);
    chk("simple_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    if (o == ALU_MTHI) m_hi = x;
    if (o == ALU_MTLO) m_lo = x;
    @(negedge clk);
    chk("simple_hi", 64'(hi_o), 64'(m_hi));
    chk("simple_lo", 64'(lo_o), 64'(m_lo));
    chk("simple_done", 64'(done), 64'd0);
  endtask

  task automatic watch_no_done(input string tag);
    int pulses;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk(tag, 64'(pulses), 64'd0);
    chk("quiet_hi", 64'(hi_o), 64'(m_hi));
    chk("quiet_lo", 64'(lo_o), 64'(m_lo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ops [7];
    logic [4:0]  o;
    logic [31:0] x, y;
    ops = '{SIG_ALU_MULT, SIG_ALU_MULTU, SIG_ALU_DIV, SIG_ALU_DIVU, ALU_MTHI, ALU_MTLO, 5'd0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    do_muldiv(SIG_ALU_MULT,  32'hFFFF_FFFE, 32'd3);
    do_muldiv(SIG_ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_muldiv(SIG_ALU_DIVU,  32'd100,       32'd7);
    do_muldiv(SIG_ALU_DIV,   32'hFFFF_FFF9, 32'd2);
    do_muldiv(SIG_ALU_DIV,   32'd5,         32'd0);
    do_muldiv(SIG_ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    do_muldiv(SIG_ALU_DIVU,  32'hDEAD_BEEF, 32'd0);
    do_simple(ALU_MTHI, 32'h1234_5678);
    do_simple(ALU_MTLO, 32'h0BAD_F00D);

    // Flush during the eleventh CALC iteration of a DIVU.
    @(posedge clk); #1;
    op = SIG_ALU_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_release", 64'(stall), 64'd0);
    watch_no_done("flush_done");

    // Flush coinciding with start in IDLE discards the op.
    @(posedge clk); #1;
    op = ALU_MTLO; a = 32'hCAFE_0001; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    op = SIG_ALU_MULT; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_stall", 64'(stall), 64'd0);
    watch_no_done("flush_start_done");

    repeat (30) begin
      o = ops[$urandom_range(0, 6)];
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      if ($urandom_range(0, 3) == 0) y = $urandom_range(1, 20);
      if ($urandom_range(0, 9) == 0) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if (is_muldiv(o)) do_muldiv(o, x, y);
      else              do_simple(o, x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
Multi-cycle multiply/divide unit with the architectural HI/LO register pair. Sits in EX beside the ALU and consumes the same a/b operands and 5-bit op code. Executes MULT/MULTU/DIV/DIVU iteratively and stalls the pipeline while busy. Also executes MTHI/MTLO writes. Supplies hi_o/lo_o to the MFHI/MFLO forwarding path.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- op  in  5  ALU control code; only MULT, MULTU, DIV, DIVU, MTHI and MTLO act here.
- start  in  1  EX-stage instruction valid for this unit.
- flush  in  1  abort the in-flight operation (exception or branch flush).
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle pulse when HI/LO take a mul/div result.
- hi_o  out  WIDTH  current HI.
- lo_o  out  WIDTH  current LO.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, HI=0, LO=0, done=0, internal accumulators cleared. stall=0 while in IDLE with start=0. rst has priority over flush and start.
- States:
  - IDLE: waiting for an operation.
  - CALC: 32 iterations, one per cycle, with a 5-bit counter counting 0..31.
  - FIX: sign correction and HI/LO write.
- In IDLE with start=1 and a mul/div op: latch |a|, |b| (raw values for unsigned ops) and the sign flags, then go to CALC.
  - stall is combinational: stall = (state != IDLE) | (start & is_muldiv & state == IDLE).
  - Stall length is 34 cycles: the start cycle, 32 CALC cycles and 1 FIX cycle.
- CALC to FIX when the counter reaches 31.
- FIX to IDLE. On that edge HI/LO are written and done pulses high for the following cycle.
  - stall is low in the cycle after FIX, so the pipeline releases and new HI/LO are visible the same cycle.
- Multiply: shift-add over 32 steps into a 64-bit accumulator. For signed ops, FIX negates the 64-bit product when sign(a) != sign(b). HI = product[63:32], LO = product[31:0].
- Divide: radix-2 restoring divide over 32 steps.
  - LO = quotient, HI = remainder.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero: defined result LO = 0xFFFFFFFF, HI = a (raw dividend), same 34-cycle latency.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO: in IDLE with start=1, HI (or LO) <= a at the next edge. No stall, no done. The new value shows on hi_o/lo_o the following cycle.
- start while not IDLE: ignored, because the pipeline is held.
- flush: at the next edge, state goes to IDLE and HI/LO are unchanged. If flush and start coincide in IDLE, the op is discarded (this includes MTHI/MTLO). stall drops the cycle after flush.
- All other op codes: no effect.

Optional Feature:
- HILO_MDU_FAST_MULT_EN defined:
  - MULT/MULTU skip CALC. The 32x32 signed/unsigned product is computed in one cycle: IDLE to FIX, then HI/LO are written.
  - Stall length is 2 cycles (start cycle plus FIX).
  - Divide is unchanged.
- Undefined: the iterative 34-cycle multiply described above.

Decomposition:
- New op codes SIG_ALU_MULT, SIG_ALU_MULTU, SIG_ALU_DIV, SIG_ALU_DIVU go into the shared define_alu_control.vh, next to the existing ALU_MTHI/ALU_MTLO.
- State encodings are local to the module.
- One sub-module, mdu_iter_core: the 64-bit shift register and add/subtract step, shared by multiply and divide, plus the iteration counter. hilo_mdu keeps the FSM, sign handling and HI/LO.

Test Plan:
- Reset, then idle for 5 cycles -> hi_o=0, lo_o=0, stall=0, done=0.
- MULT a=0xFFFFFFFE, b=3 -> stall high for exactly 34 cycles, then done pulse; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. With the macro: stall for 2 cycles, same result.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIVU a=100, b=7 -> lo_o=14, hi_o=2. DIV a=0xFFFFFFF9, b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV a=5, b=0 -> lo_o=0xFFFFFFFF, hi_o=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- MTHI a=0x12345678 -> hi_o=0x12345678 next cycle with stall=0. Then start DIVU and assert flush in CALC iteration 10 -> stall low the next cycle, no done, HI/LO unchanged.
